// File: rtl/ntt_intt_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_intt_ip_pkg
// Brief    : Shared constants and loader FSM encoding for the NTT/INTT loader.
// Revision : 1.0 - initial release
// ============================================================================
package ntt_intt_ip_pkg;

    localparam int KYBER_Q  = 3329;
    localparam int COEF_W   = 12;
    localparam int N_COEFFS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/ntt_intt_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ntt_intt_loader_fifo
// Brief    : Synchronous word FIFO with flush, occupancy count, full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_intt_loader_fifo
    import ntt_intt_ip_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int                c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]     c_depth = (c_aw+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push     = push_i & (r_count != c_depth);
    assign w_pop      = pop_i & (r_count != '0);
    assign pop_data_o = r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign full_o     = (r_count == c_depth);
    assign empty_o    = (r_count == '0);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/ntt_intt_ip_loader.sv
`default_nettype none
// ============================================================================
// Module   : ntt_intt_ip_loader
// Brief    : Buffers packed host words and streams one Kyber coefficient per
//            beat into the ntt_intt core. Build option NTT_LOADER_MODQ_EN
//            reduces coefficients >= Q instead of flagging them.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_intt_ip_loader
    import ntt_intt_ip_pkg::*;
#(
    parameter int N_COEFFS   = ntt_intt_ip_pkg::N_COEFFS,
    parameter int COEF_W     = ntt_intt_ip_pkg::COEF_W,
    parameter int FIFO_DEPTH = 4,
    parameter int Q          = KYBER_Q
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic        core_ready_i,
    output logic        load_a_f_o,
    output logic        load_a_i_o,
    output logic [31:0] din_o,
    output logic        din_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o,
    output logic        range_err_o,
    output logic [8:0]  coef_cnt_o
);

    localparam int                c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]     c_depth    = (c_aw+1)'(FIFO_DEPTH);
    localparam logic [8:0]        c_n_coeffs = 9'(N_COEFFS);
    localparam logic [8:0]        c_n_words  = 9'(N_COEFFS / 2);
    localparam logic [COEF_W-1:0] c_q        = COEF_W'(Q);

    loader_state_e     r_state;
    loader_state_e     w_state_nxt;
    logic              r_half;
    logic [8:0]        r_coef_cnt;
    logic [8:0]        r_words;
    logic [COEF_W-1:0] r_coef;
    logic              r_din_en;
    logic              r_wr_ready;
    logic              r_load_f;
    logic              r_load_i;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic [31:0]       w_fifo_rdata;
    logic [c_aw:0]     w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [31:0]       w_head;
    logic              w_head_valid;
    logic [COEF_W-1:0] w_coef_raw;
    logic [COEF_W-1:0] w_coef;
    logic [c_aw:0]     w_fifo_count_nxt;
    logic [8:0]        w_words_nxt;
    logic              w_ready_nxt;
    logic              w_unused;

    ntt_intt_loader_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (start_i),
        .push_i      (w_push),
        .push_data_i (wr_data_i),
        .pop_i       (w_pop),
        .pop_data_o  (w_fifo_rdata),
        .count_o     (w_fifo_count),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    // When the FIFO is empty the incoming word bypasses it so that its A half
    // can issue in the same cycle it is accepted; the word is still pushed so
    // the B half is available from the FIFO on the following beat.
    assign w_push       = wr_valid_i & r_wr_ready & ~start_i;
    assign w_head       = w_fifo_empty ? wr_data_i : w_fifo_rdata;
    assign w_head_valid = ~w_fifo_empty | w_push;
    assign w_issue      = (r_state == STREAM) & w_head_valid & core_ready_i
                        & (r_coef_cnt < c_n_coeffs) & ~start_i;
    assign w_pop        = w_issue & r_half;
    assign w_coef_raw   = r_half ? w_head[16 +: COEF_W] : w_head[COEF_W-1:0];
    assign w_unused     = ^{w_head[31:16+COEF_W], w_head[15:COEF_W], w_fifo_full};

`ifdef NTT_LOADER_MODQ_EN
    assign w_coef      = (w_coef_raw >= c_q) ? (w_coef_raw - c_q) : w_coef_raw;
    assign range_err_o = 1'b0;
`else
    logic r_range_err;

    assign w_coef      = w_coef_raw;
    assign range_err_o = r_range_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (start_i) begin
            r_range_err <= 1'b0;
        end else if (w_issue && (w_coef_raw >= c_q)) begin
            r_range_err <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = LOAD;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                LOAD:    w_state_nxt = STREAM;
                STREAM:  if (r_coef_cnt == c_n_coeffs) w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Write-ready is registered from next-cycle occupancy, so fullness is
    // always judged before any pop happening in the same cycle.
    assign w_fifo_count_nxt = start_i ? '0
                            : (w_fifo_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop));
    assign w_words_nxt      = start_i ? '0 : (r_words + 9'(w_push));
    assign w_ready_nxt      = ((w_state_nxt == LOAD) || (w_state_nxt == STREAM))
                            && (w_fifo_count_nxt != c_depth)
                            && (w_words_nxt < c_n_words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_half     <= 1'b0;
            r_coef_cnt <= '0;
            r_words    <= '0;
            r_coef     <= '0;
            r_din_en   <= 1'b0;
            r_wr_ready <= 1'b0;
            r_load_f   <= 1'b0;
            r_load_i   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= (w_state_nxt == DONE);
            r_load_f   <= start_i & ~mode_i;
            r_load_i   <= start_i & mode_i;
            r_wr_ready <= w_ready_nxt;
            r_words    <= w_words_nxt;
            r_din_en   <= w_issue;
            if (w_issue) r_coef <= w_coef;
            if (start_i) begin
                r_half     <= 1'b0;
                r_coef_cnt <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_half     <= ~r_half;
                    r_coef_cnt <= r_coef_cnt + 9'd1;
                end
                if (wr_valid_i && !r_wr_ready) r_overflow <= 1'b1;
            end
        end
    end

    assign wr_ready_o = r_wr_ready;
    assign load_a_f_o = r_load_f;
    assign load_a_i_o = r_load_i;
    assign din_o      = {{(32-COEF_W){1'b0}}, r_coef};
    assign din_en_o   = r_din_en;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overflow_o = r_overflow;
    assign coef_cnt_o = r_coef_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ntt_intt_ip_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_intt_ip_loader
// Brief    : Directed self-checking bench for ntt_intt_ip_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_intt_ip_loader;

`define CHECK(TAG, OBS, EXP) \
    begin \
        checks++; \
        assert ((OBS) === (EXP)) else begin \
            errors++; \
            $error("FAIL %s observed=%0d expected=%0d", TAG, (OBS), (EXP)); \
        end \
    end

`ifdef NTT_LOADER_MODQ_EN
    localparam logic [31:0] EXP_A   = 32'd0;
    localparam logic [31:0] EXP_B   = 32'd766;
    localparam logic        EXP_ERR = 1'b0;
`else
    localparam logic [31:0] EXP_A   = 32'd3329;
    localparam logic [31:0] EXP_B   = 32'd4095;
    localparam logic        EXP_ERR = 1'b1;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        core_ready;
    wire         wr_ready_o;
    wire         load_a_f_o;
    wire         load_a_i_o;
    wire  [31:0] din_o;
    wire         din_en_o;
    wire         busy_o;
    wire         done_o;
    wire         overflow_o;
    wire         range_err_o;
    wire  [8:0]  coef_cnt_o;

    int checks = 0;
    int errors = 0;

    ntt_intt_ip_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .mode_i       (mode),
        .wr_data_i    (wr_data),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready_o),
        .core_ready_i (core_ready),
        .load_a_f_o   (load_a_f_o),
        .load_a_i_o   (load_a_i_o),
        .din_o        (din_o),
        .din_en_o     (din_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .range_err_o  (range_err_o),
        .coef_cnt_o   (coef_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation log: every visible beat and pulse, stamped with a cycle index.
    logic [31:0] beats[$];
    int cyc_n = 0, done_n = 0, done_cyc = 0, last_beat_cyc = 0, lf_n = 0, li_n = 0;
    always @(negedge clk) begin
        cyc_n++;
        if (din_en_o) begin
            beats.push_back(din_o);
            last_beat_cyc = cyc_n;
        end
        if (done_o) begin
            done_n++;
            done_cyc = cyc_n;
        end
        if (load_a_f_o) lf_n++;
        if (load_a_i_o) li_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input int k);
        return {4'h0, 12'(2*k+1), 4'h0, 12'(2*k)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        wr_valid = 1'b0;
        start    = 1'b1;
        mode     = m;
        cyc();
        start    = 1'b0;
    endtask

    task automatic feed(input int first, input int nwords, input bit toggle,
                        input bit extra, input bit want_done, input int stop_beats,
                        input int base);
        int k;
        bit extra_sent;
        bit finished;
        int d0;
        k = first; extra_sent = 1'b0; finished = 1'b0; d0 = done_n;
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (toggle) core_ready = ~core_ready;
            if (k < first + nwords && wr_ready_o) begin
                wr_valid = 1'b1;
                wr_data  = word(k);
                k++;
            end else if (extra && !extra_sent && k == first + nwords) begin
                wr_valid   = 1'b1;
                wr_data    = 32'h0abc_0def;
                extra_sent = 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
            cyc();
            if (want_done) finished = (done_n != d0);
            else           finished = (beats.size() - base >= stop_beats);
        end
        wr_valid = 1'b0;
        `CHECK("feed_timeout", finished, 1'b1);
    endtask

    task automatic check_beats(input int base, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (beats[base+i] !== 32'(i)) bad++;
        `CHECK("beat_count_min", (beats.size() - base >= n), 1'b1);
        `CHECK("beat_values", bad, 0);
    endtask

    int b, lf0, li0;

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        wr_data = '0; wr_valid = 1'b0; core_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        `CHECK("reset_outputs", {wr_ready_o, load_a_f_o, load_a_i_o, din_o, din_en_o,
               busy_o, done_o, overflow_o, range_err_o, coef_cnt_o}, 49'd0);
        rst_n = 1'b1;
        cyc();
        `CHECK("idle_ready", wr_ready_o, 1'b0);

        // Write while idle is dropped
        wr_valid = 1'b1; wr_data = word(0);
        cyc();
        wr_valid = 1'b0;
        `CHECK("idle_write_overflow", overflow_o, 1'b1);
        `CHECK("idle_busy", busy_o, 1'b0);

        // Full forward load at full rate
        core_ready = 1'b1;
        lf0 = lf_n; li0 = li_n;
        do_start(1'b0);
        b = beats.size();
        `CHECK("start_busy", busy_o, 1'b1);
        `CHECK("start_load_f", load_a_f_o, 1'b1);
        `CHECK("start_load_i", load_a_i_o, 1'b0);
        `CHECK("start_clears_overflow", overflow_o, 1'b0);
        `CHECK("load_ready", wr_ready_o, 1'b1);
        feed(0, 128, 1'b0, 1'b0, 1'b1, 0, b);
        check_beats(b, 256);
        `CHECK("full_beats_total", beats.size() - b, 256);
        `CHECK("full_done_timing", done_cyc - last_beat_cyc, 1);
        `CHECK("full_busy_after", busy_o, 1'b0);
        `CHECK("full_overflow", overflow_o, 1'b0);
        `CHECK("full_cnt", coef_cnt_o, 9'd256);
        `CHECK("full_lf_pulses", lf_n - lf0, 1);
        `CHECK("full_li_pulses", li_n - li0, 0);

        // Backpressure with an excess 129th word
        do_start(1'b0);
        b = beats.size();
        feed(0, 128, 1'b1, 1'b1, 1'b1, 0, b);
        check_beats(b, 256);
        `CHECK("bp_beats_total", beats.size() - b, 256);
        `CHECK("bp_extra_overflow", overflow_o, 1'b1);
        `CHECK("bp_cnt", coef_cnt_o, 9'd256);
        `CHECK("bp_done_timing", done_cyc - last_beat_cyc, 1);

        // Five back-to-back writes against a stalled core
        core_ready = 1'b0;
        do_start(1'b0);
        b = beats.size();
        cyc();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i == 4) ? 32'h0fff_0fff : word(i);
            if (i == 4) begin
                `CHECK("fifo_full_ready", wr_ready_o, 1'b0);
                `CHECK("fifo_no_overflow_yet", overflow_o, 1'b0);
            end
            cyc();
        end
        wr_valid = 1'b0;
        `CHECK("fifo_full_drop", overflow_o, 1'b1);
        `CHECK("stall_no_beat", din_en_o, 1'b0);
        core_ready = 1'b1;
        feed(4, 124, 1'b0, 1'b0, 1'b0, 50, b);
        check_beats(b, 50);

        // Restart mid-stream as an inverse load
        li0 = li_n;
        do_start(1'b1);
        b = beats.size();
        `CHECK("restart_load_i", load_a_i_o, 1'b1);
        `CHECK("restart_load_f", load_a_f_o, 1'b0);
        `CHECK("restart_cnt", coef_cnt_o, 9'd0);
        `CHECK("restart_overflow", overflow_o, 1'b0);
        `CHECK("restart_din_en", din_en_o, 1'b0);
        feed(0, 128, 1'b0, 1'b0, 1'b1, 0, b);
        check_beats(b, 256);
        `CHECK("restart_beats_total", beats.size() - b, 256);
        `CHECK("restart_li_pulses", li_n - li0, 1);

        // Out-of-range coefficients, also checks write-to-beat latency
        do_start(1'b0);
        cyc();
        wr_valid = 1'b1;
        wr_data  = {4'h0, 12'd4095, 4'h0, 12'd3329};
        `CHECK("range_ready", wr_ready_o, 1'b1);
        cyc();
        wr_valid = 1'b0;
        `CHECK("range_a_valid", din_en_o, 1'b1);
        `CHECK("range_a", din_o, EXP_A);
        cyc();
        `CHECK("range_b_valid", din_en_o, 1'b1);
        `CHECK("range_b", din_o, EXP_B);
        cyc();
        `CHECK("range_err", range_err_o, EXP_ERR);

        // Asynchronous reset mid-stream, then a normal load
        feed(1, 20, 1'b0, 1'b0, 1'b0, 6, beats.size());
        `CHECK("pre_reset_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        `CHECK("async_reset", {wr_ready_o, load_a_f_o, load_a_i_o, din_o, din_en_o,
               busy_o, done_o, overflow_o, range_err_o, coef_cnt_o}, 49'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        lf0 = lf_n;
        do_start(1'b0);
        b = beats.size();
        `CHECK("post_reset_load_f", load_a_f_o, 1'b1);
        feed(0, 128, 1'b0, 1'b0, 1'b1, 0, b);
        check_beats(b, 256);
        `CHECK("post_reset_beats_total", beats.size() - b, 256);
        `CHECK("post_reset_range_err", range_err_o, 1'b0);
        `CHECK("post_reset_cnt", coef_cnt_o, 9'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
